window_gen_3x3: RTL

Streaming 3x3 neighbourhood generator for the image filter datapath: accepts a raster-order pixel stream with valid/ready flow control and emits one 9-pixel window per output pixel position. It uses two line buffers plus a 3x3 register array in place of the full-frame read/write arrays. It replaces the fixed 64x64, no-handshake window memory, and feeds the convolution/filter cores directly.

---
 rtl/win_pkg.sv | 28 ++
 rtl/window_gen_3x3_line_buffer.sv | 46 ++++
 rtl/window_gen_3x3.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/win_pkg.sv
`default_nettype none
// ============================================================================
// Module      : win_pkg
// Description : Shared types and helpers for the 3x3 window generator.
//               State enum, per-frame window count and window slot index.
//               Build option: WIN_PAD_EN (zero-padded windows, see top).
// Revision    : 1.0 - initial release
// ============================================================================
package win_pkg;

    // Block state: RUN accepts pixels, FLUSH pushes virtual zero pixels
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } win_state_e;

    // Number of windows emitted per frame
    function automatic int win_count(input int img_w, input int img_h, input bit pad_en);
        return pad_en ? (img_w * img_h) : ((img_w - 2) * (img_h - 2));
    endfunction

    // Slot of window pixel (row, col) inside the packed window bus
    function automatic int win_slot(input int row, input int col);
        return 3 * row + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_gen_3x3_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : DEPTH-entry delay line, one read and one write per advance.
//               rd_data is the word written DEPTH advances ago. Storage is
//               not reset; only the pointer is.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data
);

    localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);

    logic [PIX_W-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_ptr;

    // Oldest entry sits at the pointer; it is read before being overwritten
    assign rd_data = r_mem[r_ptr];

    // Circular pointer, advances once per pushed pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (r_ptr == c_ptr_last) ? '0 : r_ptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until rewritten
    always_ff @(posedge clk) begin
        if (advance) begin
            r_mem[r_ptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module      : window_gen_3x3
// Description : Streaming 3x3 neighbourhood generator. Raster pixel stream in
//               (valid/ready), one 9-pixel window per output position out.
//               Two cascaded line buffers supply the rows above the current
//               pixel; two column registers plus the incoming column form the
//               window, which is captured in a single output register.
//               Build option: WIN_PAD_EN - zero-padded windows for every pixel
//               position, with a FLUSH phase of IMG_W+1 virtual zero pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module window_gen_3x3
    import win_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIX_W-1:0]   s_pixel,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [9*PIX_W-1:0] m_win,
    output logic               m_last
);

    localparam int c_col_w = $clog2(IMG_W);
    localparam int c_row_w = $clog2(IMG_H);
    localparam int c_cnt_w = $clog2(IMG_W * IMG_H + 1);
`ifdef WIN_PAD_EN
    localparam bit c_pad_en = 1'b1;
`else
    localparam bit c_pad_en = 1'b0;
`endif
    localparam int c_num_win = win_count(IMG_W, IMG_H, c_pad_en);

    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_W - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_H - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_num_win - 1);
`ifdef WIN_PAD_EN
    localparam logic [c_col_w-1:0] c_col_one  = c_col_w'(1);
    localparam logic [c_row_w-1:0] c_row_one  = c_row_w'(1);
    localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);
    localparam int                 c_fl_w     = $clog2(IMG_W + 1);
    localparam logic [c_fl_w-1:0]  c_fl_last  = c_fl_w'(IMG_W);
`else
    localparam logic [c_col_w-1:0] c_col_two  = c_col_w'(2);
    localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);
`endif

    win_state_e         r_state;
    win_state_e         w_state_nxt;
    logic [c_col_w-1:0] r_in_col;
    logic [c_row_w-1:0] r_in_row;
    logic [c_cnt_w-1:0] r_out_cnt;

    logic               w_out_free;
    logic               w_accept;
    logic               w_advance;
    logic               w_emit;
    logic [PIX_W-1:0]   w_push_pix;
    logic [PIX_W-1:0]   w_lb0_out;
    logic [PIX_W-1:0]   w_lb1_out;
    logic [PIX_W-1:0]   w_new_col [3];
    logic [PIX_W-1:0]   r_col0    [3];
    logic [PIX_W-1:0]   r_col1    [3];
    logic [9*PIX_W-1:0] w_win;

`ifdef WIN_PAD_EN
    logic               w_inject;
    logic               w_last_pix;
    logic [c_fl_w-1:0]  r_flush_cnt;
    logic [c_col_w-1:0] r_cen_col;
    logic [c_row_w-1:0] r_cen_row;
    logic [2:0]         w_row_ok;
    logic [2:0]         w_col_ok;
`endif

    // The output register can take a new window this cycle
    assign w_out_free = m_ready || !m_valid;
    assign w_accept   = s_valid && s_ready;

`ifdef WIN_PAD_EN
    assign w_last_pix = (r_in_col == c_col_last) && (r_in_row == c_row_last);
    assign w_advance  = w_accept || w_inject;
    assign w_push_pix = w_inject ? '0 : s_pixel;
    // Centre (r,c) completes when linear index (r+1)*IMG_W+c+1 arrives;
    // every flush pixel completes one window.
    assign w_emit     = w_inject ||
                        (w_accept && ((r_in_row >= c_row_two) ||
                                      ((r_in_row == c_row_one) && (r_in_col >= c_col_one))));
`else
    assign w_advance  = w_accept;
    assign w_push_pix = s_pixel;
    assign w_emit     = w_accept && (r_in_row >= c_row_two) && (r_in_col >= c_col_two);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, input ready and flush injection
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
`ifdef WIN_PAD_EN
        w_inject    = 1'b0;
`endif
        case (r_state)
            ST_RUN: begin
                s_ready = rst_n && w_out_free;
`ifdef WIN_PAD_EN
                if (rst_n && s_valid && w_out_free && w_last_pix) begin
                    w_state_nxt = ST_FLUSH;
                end
`endif
            end
`ifdef WIN_PAD_EN
            ST_FLUSH: begin
                w_inject = w_out_free;
                if (w_out_free && (r_flush_cnt == c_fl_last)) begin
                    w_state_nxt = ST_RUN;
                end
            end
`endif
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Raster position of the next real input pixel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_col <= '0;
            r_in_row <= '0;
        end else if (w_accept) begin
            if (r_in_col == c_col_last) begin
                r_in_col <= '0;
                r_in_row <= (r_in_row == c_row_last) ? '0 : r_in_row + 1'b1;
            end else begin
                r_in_col <= r_in_col + 1'b1;
            end
        end
    end

    // Window counter; wraps after the final window of the frame is produced
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_cnt <= '0;
        end else if (w_emit) begin
            r_out_cnt <= (r_out_cnt == c_cnt_last) ? '0 : r_out_cnt + 1'b1;
        end
    end

`ifdef WIN_PAD_EN
    // Number of virtual zero pixels pushed so far in this flush
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
        end else if (w_inject) begin
            r_flush_cnt <= (r_flush_cnt == c_fl_last) ? '0 : r_flush_cnt + 1'b1;
        end
    end

    // Centre coordinate of the next window, used for border masking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cen_col <= '0;
            r_cen_row <= '0;
        end else if (w_emit) begin
            if (r_cen_col == c_col_last) begin
                r_cen_col <= '0;
                r_cen_row <= (r_cen_row == c_row_last) ? '0 : r_cen_row + 1'b1;
            end else begin
                r_cen_col <= r_cen_col + 1'b1;
            end
        end
    end

    // Bit 0: top row / left column, bit 2: bottom row / right column
    assign w_row_ok = {r_cen_row != c_row_last, 1'b1, r_cen_row != '0};
    assign w_col_ok = {r_cen_col != c_col_last, 1'b1, r_cen_col != '0};
`endif

    // Cascaded delay lines: lb0 yields the row above, lb1 two rows above
    line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_W)
    ) u_lb0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (w_advance),
        .wr_data (w_push_pix),
        .rd_data (w_lb0_out)
    );

    line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_W)
    ) u_lb1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (w_advance),
        .wr_data (w_lb0_out),
        .rd_data (w_lb1_out)
    );

    assign w_new_col[0] = w_lb1_out;
    assign w_new_col[1] = w_lb0_out;
    assign w_new_col[2] = w_push_pix;

    for (genvar gr = 0; gr < 3; gr++) begin : g_shift
        // Two older columns of the window, shifted on every pushed pixel
        always_ff @(posedge clk) begin
            if (w_advance) begin
                r_col0[gr] <= r_col1[gr];
                r_col1[gr] <= w_new_col[gr];
            end
        end
    end

    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        for (genvar gc = 0; gc < 3; gc++) begin : g_col
            logic [PIX_W-1:0] w_tap;
            if (gc == 0) begin : g_c0
                assign w_tap = r_col0[gr];
            end else if (gc == 1) begin : g_c1
                assign w_tap = r_col1[gr];
            end else begin : g_c2
                assign w_tap = w_new_col[gr];
            end
`ifdef WIN_PAD_EN
            assign w_win[PIX_W*win_slot(gr, gc) +: PIX_W] =
                (w_row_ok[gr] && w_col_ok[gc]) ? w_tap : '0;
`else
            assign w_win[PIX_W*win_slot(gr, gc) +: PIX_W] = w_tap;
`endif
        end
    end

    // Single output stage; holds window and last flag while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_win   <= '0;
            m_last  <= 1'b0;
        end else if (w_emit) begin
            m_valid <= 1'b1;
            m_win   <= w_win;
            m_last  <= (r_out_cnt == c_cnt_last);
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire
